// File: rtl/tm1638_frame_ctrl.sv
// Frame sequencer for the TM1638 SPI engine. It snapshots the display image,
// issues 19 transactions per frame, captures the key-scan word, then waits out a refresh interval.
module tm1638_frame_ctrl #(
  parameter  int REFRESH_CYCLES = 250000,
  localparam int CNT_WIDTH      = $clog2(REFRESH_CYCLES + 1)
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic [127:0] i_Seg_Data,
  input  logic [2:0]   i_Brightness,
  input  logic         i_Display_On,
  output logic         o_SPI_Data_Ready,
  output logic [17:0]  o_SPI_Data,
  input  logic         i_SPI_Busy,
  input  logic [31:0]  i_SPI_Read_Data,
  output logic [31:0]  o_Keys,
  output logic         o_Keys_Valid,
  output logic         o_Frame_Done
);

  typedef enum logic [2:0] {
    S_FRAME_START,
    S_ISSUE,
    S_ACK,
    S_DONE,
    S_REFRESH
  } state_e;

  localparam logic [4:0]           LAST_IDX = 5'd18;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(REFRESH_CYCLES - 1);

  state_e               state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [127:0]         snap_seg_q, snap_seg_d;
  logic [2:0]           snap_bri_q, snap_bri_d;
  logic                 snap_on_q, snap_on_d;
  logic                 ready_q, ready_d;
  logic [17:0]          data_q, data_d;
  logic [31:0]          keys_q, keys_d;
  logic                 keys_valid_q, keys_valid_d;
  logic                 frame_done_q, frame_done_d;

  // Word for a transaction index: mode command, 16 data writes, display control, key scan.
  function automatic logic [17:0] table_word(input logic [4:0]   idx,
                                             input logic [127:0] seg,
                                             input logic [2:0]   bri,
                                             input logic         on);
    logic [3:0] k;
    k = 4'(idx - 5'd1);
    if (idx == 5'd0)
      table_word = 18'h00044;
    else if (idx <= 5'd16)
      table_word = {1'b0, 1'b1, seg[{k, 3'b000} +: 8], 8'hC0 | {4'h0, k}};
    else if (idx == 5'd17)
      table_word = {10'h000, on ? (8'h88 | {5'b00000, bri}) : 8'h80};
    else
      table_word = 18'h20042;
  endfunction

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    snap_seg_d   = snap_seg_q;
    snap_bri_d   = snap_bri_q;
    snap_on_d    = snap_on_q;
    data_d       = data_q;
    keys_d       = keys_q;
    ready_d      = 1'b0;
    keys_valid_d = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_FRAME_START: begin
        snap_seg_d = i_Seg_Data;
        snap_bri_d = i_Brightness;
        snap_on_d  = i_Display_On;
        idx_d      = 5'd0;
        data_d     = table_word(5'd0, i_Seg_Data, i_Brightness, i_Display_On);
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (!i_SPI_Busy) begin
          ready_d = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (i_SPI_Busy) state_d = S_DONE;
      end
      S_DONE: begin
        if (!i_SPI_Busy) begin
          if (idx_q == LAST_IDX) begin
            keys_d       = i_SPI_Read_Data;
            keys_valid_d = 1'b1;
            frame_done_d = 1'b1;
            cnt_d        = '0;
            state_d      = S_REFRESH;
          end else begin
            idx_d   = idx_q + 5'd1;
            data_d  = table_word(idx_q + 5'd1, snap_seg_q, snap_bri_q, snap_on_q);
            state_d = S_ISSUE;
          end
        end
      end
      S_REFRESH: begin
        if (cnt_q == CNT_LAST) state_d = S_FRAME_START;
        else                   cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
      default: state_d = S_FRAME_START;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= S_FRAME_START;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_seg_q   <= '0;
      snap_bri_q   <= '0;
      snap_on_q    <= 1'b0;
      ready_q      <= 1'b0;
      data_q       <= '0;
      keys_q       <= '0;
      keys_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_seg_q   <= snap_seg_d;
      snap_bri_q   <= snap_bri_d;
      snap_on_q    <= snap_on_d;
      ready_q      <= ready_d;
      data_q       <= data_d;
      keys_q       <= keys_d;
      keys_valid_q <= keys_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_SPI_Data_Ready = ready_q;
  assign o_SPI_Data       = data_q;
  assign o_Keys           = keys_q;
  assign o_Keys_Valid     = keys_valid_q;
  assign o_Frame_Done     = frame_done_q;

endmodule

// File: tb/tb_tm1638_frame_ctrl.sv
// Directed bench for tm1638_frame_ctrl: the bench plays the SPI engine (10 busy cycles per
// transaction) and checks the command stream, key capture, refresh timing, busy gating and reset.
module tb_tm1638_frame_ctrl;

  localparam int REFRESH = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] i_Seg_Data;
  logic [2:0]   i_Brightness;
  logic         i_Display_On;
  logic         o_SPI_Data_Ready;
  logic [17:0]  o_SPI_Data;
  logic         i_SPI_Busy;
  logic [31:0]  i_SPI_Read_Data;
  logic [31:0]  o_Keys;
  logic         o_Keys_Valid;
  logic         o_Frame_Done;

  int n_checks = 0;
  int n_errors = 0;

  tm1638_frame_ctrl #(.REFRESH_CYCLES(REFRESH)) dut (
    .i_Clk            (clk),
    .i_Rst_n          (rst_n),
    .i_Seg_Data       (i_Seg_Data),
    .i_Brightness     (i_Brightness),
    .i_Display_On     (i_Display_On),
    .o_SPI_Data_Ready (o_SPI_Data_Ready),
    .o_SPI_Data       (o_SPI_Data),
    .i_SPI_Busy       (i_SPI_Busy),
    .i_SPI_Read_Data  (i_SPI_Read_Data),
    .o_Keys           (o_Keys),
    .o_Keys_Valid     (o_Keys_Valid),
    .o_Frame_Done     (o_Frame_Done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Expected data-write word for display byte k of an image.
  function automatic logic [17:0] data_word(input int k, input logic [127:0] seg);
    logic [7:0] b;
    b = seg[8*k +: 8];
    return {2'b01, b, 8'hC0 | 8'(k)};
  endfunction

  // Wait (bounded) for a ready pulse, check the word, then act as the SPI engine for 10 cycles.
  task automatic serve(input string tag, input logic [17:0] exp_word, input logic [31:0] rd);
    int n = 0;
    while (o_SPI_Data_Ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready"}, 32'(o_SPI_Data_Ready), 32'd1);
    check({tag, " word"}, 32'(o_SPI_Data), 32'(exp_word));
    i_SPI_Read_Data = rd;
    i_SPI_Busy      = 1'b1;
    @(negedge clk);
    check({tag, " pulse"}, 32'(o_SPI_Data_Ready), 32'd0);
    repeat (9) @(negedge clk);
    i_SPI_Busy = 1'b0;
  endtask

  logic [127:0] seg_a, seg_b;
  logic [17:0]  word4;
  int           bad;
  int           n;

  initial begin
    for (int k = 0; k < 16; k++) seg_a[8*k +: 8] = 8'(k * 17);
    seg_a[7:0]     = 8'h3F;
    seg_a[127:120] = 8'h06;
    seg_b          = seg_a;
    seg_b[47:40]   = 8'hE7;

    rst_n           = 1'b0;
    i_Seg_Data      = seg_a;
    i_Brightness    = 3'd7;
    i_Display_On    = 1'b1;
    i_SPI_Busy      = 1'b0;
    i_SPI_Read_Data = 32'h0;

    repeat (3) @(negedge clk);
    check("rst ready", 32'(o_SPI_Data_Ready), 32'd0);
    check("rst data",  32'(o_SPI_Data),       32'd0);
    check("rst keys",  o_Keys,                32'd0);
    check("rst valid", 32'(o_Keys_Valid),     32'd0);
    check("rst done",  32'(o_Frame_Done),     32'd0);
    rst_n = 1'b1;

    // Frame 1: brightness 7, display on
    serve("f1 t0", 18'h00044, 32'h0);
    serve("f1 t1", 18'h13FC0, 32'h0);
    serve("f1 t2", data_word(1, seg_a), 32'h0);
    serve("f1 t3", data_word(2, seg_a), 32'h0);

    // DONE->ISSUE for index 4 happens at the next edge; then the engine stays busy 500 cycles
    @(negedge clk);
    i_SPI_Busy = 1'b1;
    i_Seg_Data = seg_b;
    word4 = data_word(3, seg_a);
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (o_SPI_Data_Ready !== 1'b0 || o_SPI_Data !== word4) bad++;
    end
    check("hold no ready, word stable", 32'(bad), 32'd0);
    check("hold word", 32'(o_SPI_Data), 32'(word4));
    i_SPI_Busy = 1'b0;

    for (int k = 3; k < 15; k++) serve($sformatf("f1 t%0d", k + 1), data_word(k, seg_a), 32'h0);
    serve("f1 t16", 18'h106CF, 32'h0);
    serve("f1 t17", 18'h0008F, 32'h0);
    serve("f1 t18", 18'h20042, 32'hA5000001);

    @(negedge clk);
    check("f1 keys",  o_Keys,                32'hA5000001);
    check("f1 valid", 32'(o_Keys_Valid),     32'd1);
    check("f1 done",  32'(o_Frame_Done),     32'd1);
    i_Brightness = 3'd3;
    i_Display_On = 1'b0;
    @(negedge clk);
    check("f1 valid one cycle", 32'(o_Keys_Valid), 32'd0);
    check("f1 done one cycle",  32'(o_Frame_Done), 32'd0);

    // Done pulse cycle, REFRESH cycles of refresh, FRAME_START, ISSUE, then the ready pulse:
    // the ready pulse is sampled REFRESH+2 negedges after the done pulse.
    n = 1;
    while (o_SPI_Data_Ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("refresh gap", 32'(n), 32'(REFRESH + 2));

    // Frame 2: new image (byte5 changed), display off
    serve("f2 t0", 18'h00044, 32'h0);
    for (int k = 0; k < 16; k++) serve($sformatf("f2 t%0d", k + 1), data_word(k, seg_b), 32'h0);
    serve("f2 t17", 18'h00080, 32'h0);
    serve("f2 t18", 18'h20042, 32'h12345678);
    @(negedge clk);
    check("f2 keys",  o_Keys,            32'h12345678);
    check("f2 valid", 32'(o_Keys_Valid), 32'd1);
    check("f2 done",  32'(o_Frame_Done), 32'd1);
    i_Display_On = 1'b1;

    // Frame 3: display on, brightness 3; reset lands while waiting in DONE of the key scan
    serve("f3 t0", 18'h00044, 32'h0);
    check("f3 t6 byte5 new", 32'(data_word(5, seg_b)), 32'h1E7C5);
    for (int k = 0; k < 16; k++) serve($sformatf("f3 t%0d", k + 1), data_word(k, seg_b), 32'h0);
    serve("f3 t17", 18'h0008B, 32'h0);
    n = 0;
    while (o_SPI_Data_Ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("f3 t18 word", 32'(o_SPI_Data), 32'h20042);
    i_SPI_Busy = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst ready", 32'(o_SPI_Data_Ready), 32'd0);
    check("midrst data",  32'(o_SPI_Data),       32'd0);
    check("midrst keys",  o_Keys,                32'd0);
    check("midrst valid", 32'(o_Keys_Valid),     32'd0);
    check("midrst done",  32'(o_Frame_Done),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_SPI_Data_Ready !== 1'b0) bad++;
    end
    check("post-rst gated by busy", 32'(bad), 32'd0);
    i_SPI_Busy = 1'b0;
    serve("post-rst t0", 18'h00044, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tm1638_frame_ctrl.md
Name: tm1638_frame_ctrl

Overview:
- Upstream sequencer for the TM1638 SPI transaction engine.
- Each frame it snapshots a 16-byte display image and issues the full command sequence to the SPI engine through its ready/busy handshake: address-mode command, 16 fixed-address data writes, display control, then key-scan read.
- It latches the returned 32-bit key word, then idles for a programmable refresh interval before starting the next frame.

Parameters:
- REFRESH_CYCLES, 250000, idle i_Clk cycles between the end of one frame and the start of the next (minimum 1).
- CNT_WIDTH, $clog2(REFRESH_CYCLES+1), width of the refresh counter (derived, not overridden).

Ports:
- i_Clk  in  1  system clock; all logic on posedge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Seg_Data  in  128  display image; byte k = [8k+7:8k] goes to TM1638 address k.
- i_Brightness  in  3  pulse-width setting 0..7.
- i_Display_On  in  1  1 = display enabled.
- o_SPI_Data_Ready  out  1  transaction request to SPI engine.
- o_SPI_Data  out  18  word: [17] read-follows flag, [16] data-byte-present, [15:8] data, [7:0] command.
- i_SPI_Busy  in  1  SPI engine busy.
- i_SPI_Read_Data  in  32  key-scan result from SPI engine.
- o_Keys  out  32  last captured key word.
- o_Keys_Valid  out  1  one-cycle pulse when o_Keys updates.
- o_Frame_Done  out  1  one-cycle pulse at end of each frame.

Behaviour:
- Reset (async assert, sync release): all outputs 0; transaction index 0; refresh counter 0; state FRAME_START.
- Main FSM: FRAME_START -> ISSUE -> ACK -> DONE -> (next transaction: ISSUE | last: REFRESH) -> FRAME_START.
- FRAME_START, one cycle:
  - Registers i_Seg_Data, i_Brightness and i_Display_On into a snapshot.
  - Sets index to 0.
  - Later input changes do not affect the current frame.
- Transaction table (index : o_SPI_Data):
  - 0 : 18'h00044 (write data, fixed address).
  - 1..16, k = index-1 : {1'b0, 1'b1, snap byte k, 8'hC0|k}.
  - 17 : {10'h000, on ? 8'h88|bri : 8'h80}.
  - 18 : 18'h20042 (key scan, read follows).
- ISSUE:
  - o_SPI_Data is driven with the table word.
  - While i_SPI_Busy = 1, o_SPI_Data_Ready stays 0 and the FSM waits.
  - When i_SPI_Busy = 0, o_SPI_Data_Ready = 1 for exactly one cycle, then go to ACK.
- ACK: wait for i_SPI_Busy = 1 (normally the next cycle), then go to DONE. o_SPI_Data_Ready stays 0 in ACK; no re-issue.
- DONE: wait for i_SPI_Busy = 0.
  - If index = 18: o_Keys <= i_SPI_Read_Data; o_Keys_Valid pulses the same cycle the capture lands.
  - Then, if index < 18: index += 1 and go to ISSUE.
  - Otherwise pulse o_Frame_Done and go to REFRESH.
- o_SPI_Data holds its value from ISSUE through DONE. It changes only on the ISSUE entry for the next index.
- REFRESH: counter counts 0..REFRESH_CYCLES-1, then FRAME_START. Counter clears on REFRESH entry.
- Frame length: 19 transactions. Exactly one o_SPI_Data_Ready pulse per transaction; never two without an intervening busy high/low cycle.
- Simultaneous events: o_Keys_Valid and o_Frame_Done pulse in the same cycle.
- Reset mid-frame: immediate abort. Outputs return to reset values; o_Keys clears to 0. After release a new frame starts. ISSUE gating on i_SPI_Busy covers an SPI engine still completing.
- Arithmetic: index is 5 bits, range 0..18. 8'hC0|k uses the 4-bit k. Brightness is 3 bits, no saturation needed.
- All outputs are registered; no combinational path from i_SPI_Busy to o_SPI_Data_Ready.

Test Plan:
- Reset, then model SPI busy for 10 cycles per transaction; i_Seg_Data byte0 = 8'h3F, byte15 = 8'h06 -> 19 ready pulses in order:
  - 18'h00044
  - 18'h13FC0 ... 18'h106CF
  - 18'h0008F (bri = 7, on)
  - 18'h20042
  - then o_Frame_Done.
- i_Display_On = 0, i_Brightness = 3 -> control word 18'h00080. With on = 1, bri = 3 -> 18'h0008B.
- Model returns 32'hA5000001 on the read -> o_Keys = 32'hA5000001 with a single o_Keys_Valid pulse, coincident with o_Frame_Done.
- Change i_Seg_Data byte5 mid-frame, after transaction 3 -> current frame still sends the old byte5; next frame sends the new value.
- Hold i_SPI_Busy high 500 cycles before transaction 4 -> no ready pulse until busy falls; o_SPI_Data stable throughout.
- REFRESH_CYCLES = 20 -> exactly 20 cycles from o_Frame_Done cycle+1 to FRAME_START. Assert i_Rst_n low mid-DONE -> all outputs 0 asynchronously; after release, transaction 0 is reissued.
